// File: rtl/oem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oem_pkg
// Description : Shared constants and sentinel helper for the odd-even merge
//               stream loader and the downstream trimmer.
// Revision    : 1.0 - initial release
// ============================================================================
package oem_pkg;

    localparam int c_oem_log_input = 4;
    localparam int c_oem_lane_w    = 8;
    localparam int c_oem_count_w   = c_oem_log_input + 1;
    localparam int c_oem_max_w     = 64;

    // Pad value that sorts to the tail for the given sort direction and signedness.
    function automatic logic [c_oem_max_w-1:0] oem_sentinel(
        input bit is_signed,
        input bit ascending,
        input int width
    );
        logic [c_oem_max_w-1:0] s;
        s = '0;
        for (int i = 0; i < c_oem_max_w; i++) begin
            if (i < width) s[i] = ascending;
        end
        if (is_signed && (width > 0)) s[width-1] = !ascending;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oem_flush_timer.sv
`default_nettype none
// ============================================================================
// Module      : oem_flush_timer
// Description : Saturating idle counter; expired fires on the edge where the
//               count of idle cycles reaches TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module oem_flush_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int                 c_cnt_w = $clog2(TIMEOUT + 1);
            localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(TIMEOUT);
            localparam logic [c_cnt_w-1:0] c_fire  = c_cnt_w'(TIMEOUT - 1);

            logic [c_cnt_w-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_count <= '0;
                end else if (run && (r_count != c_max)) begin
                    r_count <= r_count + c_cnt_w'(1);
                end
            end

            // The increment on this edge would reach TIMEOUT, so flush now.
            assign expired = run && (r_count >= c_fire);
        end else begin : g_no_timer
            assign expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/odd_even_merge_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : odd_even_merge_stream_loader
// Description : Packs a valid/ready element stream into sentinel-padded
//               parallel frames for the odd-even merge sorting network.
// Revision    : 1.0 - initial release
// ============================================================================
module odd_even_merge_stream_loader
    import oem_pkg::*;
#(
    parameter int LOG_INPUT     = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int SIGNED        = 0,
    parameter int ASCENDING     = 1,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_valid,
    input  logic                                   s_last,
    output logic                                   s_ready,
    output logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]   x,
    output logic                                   x_valid,
    output logic [LOG_INPUT:0]                     x_count
);

    localparam int c_n     = 2 ** LOG_INPUT;
    localparam int c_cnt_w = LOG_INPUT + 1;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_fill = 1'b1;

    localparam logic [c_oem_max_w-1:0] c_sent_full =
        oem_sentinel(SIGNED != 0, ASCENDING != 0, DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0]  c_sentinel  = c_sent_full[DATA_WIDTH-1:0];
    localparam logic [LOG_INPUT-1:0]   c_last_idx  = '1;

    logic                          r_ready;
    logic [0:0]                    r_state;
    logic [LOG_INPUT-1:0]          r_wr_idx;
    logic [DATA_WIDTH-1:0]         r_lanes [c_n];
    logic [DATA_WIDTH*c_n-1:0]     r_x;
    logic                          r_x_valid;
    logic [c_cnt_w-1:0]            r_x_count;

    logic                          w_accept;
    logic                          w_full;
    logic                          w_run;
    logic                          w_expired;
    logic                          w_emit;
    logic [c_cnt_w-1:0]            w_count;
    logic [DATA_WIDTH*c_n-1:0]     w_frame;

    assign w_accept = s_valid && r_ready;
    assign w_full   = w_accept && (r_wr_idx == c_last_idx);
    // An accept always beats the timeout, so the timer only runs on idle FILL cycles.
    assign w_run    = (r_state == c_st_fill) && !w_accept;
    assign w_emit   = (w_accept && (s_last || w_full)) || w_expired;
    assign w_count  = {1'b0, r_wr_idx} + {{LOG_INPUT{1'b0}}, w_accept};

    oem_flush_timer #(
        .TIMEOUT (FLUSH_TIMEOUT)
    ) u_flush_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept || w_emit),
        .run     (w_run),
        .expired (w_expired)
    );

    always_comb begin
        w_frame = '0;
        for (int k = 0; k < c_n; k++) begin
            if (w_accept && (LOG_INPUT'(k) == r_wr_idx)) begin
                w_frame[DATA_WIDTH*k +: DATA_WIDTH] = s_data;
            end else if (c_cnt_w'(k) < {1'b0, r_wr_idx}) begin
                w_frame[DATA_WIDTH*k +: DATA_WIDTH] = r_lanes[k];
            end else begin
                w_frame[DATA_WIDTH*k +: DATA_WIDTH] = c_sentinel;
            end
        end
    end

    // Lane storage needs no reset: lanes at or above wr_idx are never read back.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lanes[r_wr_idx] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready   <= 1'b0;
            r_state   <= c_st_idle;
            r_wr_idx  <= '0;
            r_x       <= '0;
            r_x_valid <= 1'b0;
            r_x_count <= '0;
        end else begin
            r_ready   <= 1'b1;
            r_x_valid <= w_emit;
            if (w_emit) begin
                r_x       <= w_frame;
                r_x_count <= w_count;
                r_wr_idx  <= '0;
                r_state   <= c_st_idle;
            end else if (w_accept) begin
                r_wr_idx  <= r_wr_idx + LOG_INPUT'(1);
                r_state   <= c_st_fill;
            end
        end
    end

    assign s_ready = r_ready;
    assign x       = r_x;
    assign x_valid = r_x_valid;
    assign x_count = r_x_count;

endmodule
`default_nettype wire

// File: tb/tb_odd_even_merge_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_odd_even_merge_stream_loader
// Description : Directed bench; three loader variants (unsigned asc, signed
//               asc, signed desc) share one input stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_odd_even_merge_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;

    logic        rdy_u, rdy_s, rdy_d;
    logic [31:0] x_u, x_s, x_d;
    logic        xv_u, xv_s, xv_d;
    logic [2:0]  cnt_u, cnt_s, cnt_d;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    odd_even_merge_stream_loader #(
        .LOG_INPUT(2), .DATA_WIDTH(8), .SIGNED(0), .ASCENDING(1), .FLUSH_TIMEOUT(4)
    ) dut_u (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(rdy_u), .x(x_u), .x_valid(xv_u), .x_count(cnt_u)
    );

    odd_even_merge_stream_loader #(
        .LOG_INPUT(2), .DATA_WIDTH(8), .SIGNED(1), .ASCENDING(1), .FLUSH_TIMEOUT(4)
    ) dut_s (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(rdy_s), .x(x_s), .x_valid(xv_s), .x_count(cnt_s)
    );

    odd_even_merge_stream_loader #(
        .LOG_INPUT(2), .DATA_WIDTH(8), .SIGNED(1), .ASCENDING(0), .FLUSH_TIMEOUT(4)
    ) dut_d (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(rdy_d), .x(x_d), .x_valid(xv_d), .x_count(cnt_d)
    );

    typedef struct {
        int              n;
        logic [3:0][7:0] d;
        bit              last;
        logic [31:0]     exp_u;
        logic [31:0]     exp_s;
        logic [31:0]     exp_d;
        logic [2:0]      exp_cnt;
        int              exp_lat;
    } vec_t;

    vec_t tbl [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(output int lat);
        lat = 0;
        while (!xv_u && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;

        // lane 0 is the least significant byte of d and of the expected frames
        tbl[0] = '{4, {8'h01, 8'h09, 8'h03, 8'h05}, 1'b0,
                   32'h01090305, 32'h01090305, 32'h01090305, 3'd4, 0};
        tbl[1] = '{2, {8'h00, 8'h00, 8'h02, 8'h07}, 1'b1,
                   32'hFFFF0207, 32'h7F7F0207, 32'h80800207, 3'd2, 0};
        tbl[2] = '{1, {8'h00, 8'h00, 8'h00, 8'h04}, 1'b0,
                   32'hFFFFFF04, 32'h7F7F7F04, 32'h80808004, 3'd1, 4};
        tbl[3] = '{1, {8'h00, 8'h00, 8'h00, 8'h10}, 1'b1,
                   32'hFFFFFF10, 32'h7F7F7F10, 32'h80808010, 3'd1, 0};
        tbl[4] = '{3, {8'h00, 8'hCC, 8'hBB, 8'hAA}, 1'b0,
                   32'hFFCCBBAA, 32'h7FCCBBAA, 32'h80CCBBAA, 3'd3, 4};
        tbl[5] = '{3, {8'h00, 8'h7F, 8'h00, 8'h80}, 1'b1,
                   32'hFF7F0080, 32'h7F7F0080, 32'h807F0080, 3'd3, 0};

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        step();
        step();
        check("reset_x",       x_u,             32'h0);
        check("reset_x_valid", {31'b0, xv_u},   32'h0);
        check("reset_x_count", {29'b0, cnt_u},  32'h0);
        check("reset_s_ready", {31'b0, rdy_u},  32'h0);
        rst = 1'b0;
        step();
        check("ready_rise", {29'b0, rdy_u, rdy_s, rdy_d}, 32'h7);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < tbl[v].n; i++) begin
                s_valid = 1'b1;
                s_data  = tbl[v].d[i];
                s_last  = tbl[v].last && (i == tbl[v].n - 1);
                step();
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            wait_pulse(lat);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(tbl[v].exp_lat));
            check($sformatf("vec%0d_x_uns", v),   x_u, tbl[v].exp_u);
            check($sformatf("vec%0d_x_sgn", v),   x_s, tbl[v].exp_s);
            check($sformatf("vec%0d_x_desc", v),  x_d, tbl[v].exp_d);
            check($sformatf("vec%0d_count", v),   {29'b0, cnt_u}, {29'b0, tbl[v].exp_cnt});
            check($sformatf("vec%0d_pulse_all", v), {30'b0, xv_s, xv_d}, 32'h3);
            step();
            check($sformatf("vec%0d_pulse_end", v), {31'b0, xv_u}, 32'h0);
        end

        // Accept on the would-be timeout edge defers the flush.
        s_valid = 1'b1; s_data = 8'h11;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("defer_idle%0d", i), {31'b0, xv_u}, 32'h0);
        end
        s_valid = 1'b1; s_data = 8'h22;
        step();
        check("defer_no_flush", {31'b0, xv_u}, 32'h0);
        s_valid = 1'b0;
        wait_pulse(lat);
        check("defer_latency", 32'(lat), 32'd4);
        check("defer_x",       x_u, 32'hFFFF2211);
        check("defer_count",   {29'b0, cnt_u}, 32'd2);
        step();

        // Eight elements at full rate: pulses after the 4th and 8th accepts.
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i + 1);
            step();
            check($sformatf("b2b_pulse%0d", i), {31'b0, xv_u}, {31'b0, (i == 3 || i == 7)});
            check($sformatf("b2b_ready%0d", i), {31'b0, rdy_u}, 32'h1);
            if (i == 3) check("b2b_frame0", x_u, 32'h04030201);
            if (i == 7) check("b2b_frame1", x_u, 32'h08070605);
        end
        s_valid = 1'b0;
        step();

        // Reset on an edge where an emit would otherwise occur.
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1; rst = 1'b1;
        step();
        check("rst_emit_suppressed", {31'b0, xv_u}, 32'h0);
        check("rst_ready_low",       {31'b0, rdy_u}, 32'h0);
        s_valid = 1'b0; s_last = 1'b0; rst = 1'b0;
        step();

        // Reset mid-frame discards the partial frame.
        s_valid = 1'b1; s_data = 8'hEE;
        step();
        s_data = 8'hDD;
        step();
        s_valid = 1'b0; rst = 1'b1;
        step();
        check("midrst_x_valid", {31'b0, xv_u}, 32'h0);
        check("midrst_x",       x_u, 32'h0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i + 1);
            step();
            check($sformatf("midrst_pulse%0d", i), {31'b0, xv_u}, {31'b0, (i == 3)});
        end
        s_valid = 1'b0;
        check("midrst_frame", x_u, 32'h04030201);
        check("midrst_count", {29'b0, cnt_u}, 32'd4);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("midrst_quiet%0d", i), {31'b0, xv_u}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/odd_even_merge_stream_loader.md
# odd_even_merge_stream_loader

Upstream feeder for the odd-even merge sorting network. It accepts a serial element stream over a valid/ready handshake and packs 2**LOG_INPUT elements into one parallel frame. It drives the network's `x`/`x_valid` inputs with a one-cycle pulse per frame. Short frames, ended by `s_last` or an idle timeout, are padded with a sentinel value that sorts to the tail, and the true element count travels alongside each frame.

## Interface
- `LOG_INPUT`, 4: log2 of frame size, N = 2**LOG_INPUT; must be ≥1.
- `DATA_WIDTH`, 8: element width in bits.
- `SIGNED`, 0: 1 means elements are two's complement (sentinel choice only).
- `ASCENDING`, 1: matches the network's sort direction (sentinel choice only).
- `FLUSH_TIMEOUT`, 16: idle cycles before a partial frame is flushed; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  DATA_WIDTH  stream element.
- `s_valid`  in  1  `s_data` is valid.
- `s_last`  in  1  qualifies `s_data` as the final element of a frame.
- `s_ready`  out  1  loader accepts when high.
- `x`  out  DATA_WIDTH*N  packed frame; element k occupies bits [DATA_WIDTH*k +: DATA_WIDTH].
- `x_valid`  out  1  one-cycle frame strobe to the network.
- `x_count`  out  LOG_INPUT+1  real elements in `x` (1..N).

## Operation
- **Accept rule:** an element is accepted on any edge where `s_valid && s_ready`. The element is written to lane `wr_idx`, and `wr_idx` then increments.
- **States:**
  - IDLE (`wr_idx` = 0). An accept moves to FILL, unless that accept also completes the frame.
  - FILL (0 < `wr_idx` < N). Leaves to IDLE on emit.
- **Emit conditions:** a frame is emitted when any of these holds:
  - an accept fills lane N-1;
  - an accept carries `s_last`;
  - in FILL, the idle timer reaches FLUSH_TIMEOUT.
- **Emit actions:** at the emit edge:
  - `x` is loaded with the buffered lanes plus the accepted element, if any;
  - lanes ≥ count are loaded with the sentinel;
  - `x_count` = count;
  - `x_valid` = 1 for the next cycle only;
  - `wr_idx` = 0.
- **Sentinel values:**
  - ASCENDING=1: all-ones if unsigned, 0 followed by ones if signed.
  - ASCENDING=0: all-zeros if unsigned, 1 followed by zeros if signed.
- **Idle timer:**
  - Counts cycles in FILL with no accept.
  - Clears on every accept and on every emit.
  - Width is clog2(FLUSH_TIMEOUT+1).
  - Saturates at FLUSH_TIMEOUT.
- **Simultaneous accept and timeout:** the accept wins. The element joins the frame and the timer clears. The frame emits only if that accept itself completes it.
- **`s_last` in IDLE:** emits a 1-element frame with `x_count` = 1.
- **Back-to-back frames:** the loader must accept an element in the same cycle `x_valid` is high. That element goes to lane 0 of the next frame, so there are no bubbles.
- **`x` hold:** `x` and `x_count` hold their values until the next emit. The network samples `x` only under `x_valid`.

## Timing
- **Reset values:**
  - `x` = 0, `x_valid` = 0, `x_count` = 0;
  - `s_ready` = 0;
  - `wr_idx` = 0, timer = 0.
- **`s_ready`:** rises on the first edge after `rst` deasserts and then stays 1. The loader never stalls, because the network has no backpressure.
- **Latency:** from the completing accept edge t, `x_valid` is high during cycle t+1.
- **Timeout flush:** after the last accept at edge t, `x_valid` is high in cycle t+FLUSH_TIMEOUT+1.
- **Throughput:** at full rate, one frame every N cycles.
- **`rst` mid-frame:** the partial frame is discarded with no emit. `x_valid` is forced low on the reset edge, even if an emit was due.

## Structure
- **Shared package** (`oem_pkg`):
  - `LANE_W` = DATA_WIDTH;
  - count width `LOG_INPUT+1`;
  - function `oem_sentinel(SIGNED, ASCENDING, DATA_WIDTH)`. The downstream trimmer reuses it.
- **Sub-module** `oem_flush_timer`: the idle counter, with `clear`, `run` and `expired`. It is tied off to `expired` = 0 when FLUSH_TIMEOUT = 0.
- **Top level:** the lane buffer, `wr_idx` and the emit register.

## Test plan
All scenarios use LOG_INPUT=2, DATA_WIDTH=8, FLUSH_TIMEOUT=4.
- **Full frame, unsigned ascending:** stream 5, 3, 9, 1 back-to-back → one `x_valid` pulse the cycle after the 4th accept; `x` lanes = {5,3,9,1}, `x_count` = 4.
- **`s_last` short frame:** stream 7, 2 with `s_last` on 2, unsigned ascending → lanes {7,2,FF,FF}, `x_count` = 2; the same case with SIGNED=1 gives {7,2,7F,7F}.
- **Timeout flush:** accept 4, then idle → `x_valid` exactly 5 cycles after the accept; lanes {4,FF,FF,FF}, `x_count` = 1. A new accept on cycle 4 of idle defers the flush.
- **Back-to-back frames:** 8 elements at full rate → pulses exactly 4 cycles apart, no dropped element, `s_ready` constantly 1.
- **Descending sentinel:** ASCENDING=0, SIGNED=1, `s_last` on the first element 0x10 → lanes {10,80,80,80}.
- **Reset mid-frame:** accept 2 elements, assert `rst` for 1 cycle, then stream 1, 2, 3, 4 → one frame {1,2,3,4}, no frame from the discarded elements.
